// File: rtl/pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_ctrl                                                     |
// | Purpose  : 5-stage pipeline stall/flush/redirect controller with a       |
// |            MEM-wait timeout; PIPE_CTRL_PERF_EN adds perf counters.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef STOP
`define STOP 1'b1
`endif
`ifndef NOSTOP
`define NOSTOP 1'b0
`endif

module pipe_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     stallreq_id_i,
   input  logic                     stallreq_ex_i,
   input  logic                     stallreq_mem_i,
   input  logic                     jump_en_i,
   input  logic [`ADDR_WIDTH-1:0]   jump_addr_i,
   output logic [5:0]               stall_o,
   output logic                     flush_o,
   output logic                     jump_en_o,
   output logic [`ADDR_WIDTH-1:0]   jump_addr_o,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0]              stall_cycles_o,
   output logic [31:0]              flush_cnt_o,
`endif
   output logic                     timeout_o
);

   localparam logic [CNT_W-1:0] c_timeout = CNT_W'(MEM_TIMEOUT);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [`ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     timeout_q, timeout_d;
   logic                     w_blk;
   logic [5:0]               w_stall_vec;

   always_comb begin
      w_blk = stallreq_mem_i | stallreq_ex_i;

      if (stallreq_mem_i)
         w_stall_vec = 6'b011111;
      else if (stallreq_ex_i)
         w_stall_vec = 6'b001111;
      else if (stallreq_id_i)
         w_stall_vec = 6'b000111;
      else
         w_stall_vec = 6'b000000;

      state_d     = state_q;
      pend_addr_d = pend_addr_q;
      stall_o     = w_stall_vec;
      flush_o     = 1'b0;
      jump_en_o   = 1'b0;
      jump_addr_o = '0;

      // While in reset every combinational output is held quiet.
      if (rst_i) begin
         stall_o = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (jump_en_i) begin
                  if (!w_blk) begin
                     jump_en_o   = 1'b1;
                     jump_addr_o = jump_addr_i;
                     flush_o     = 1'b1;
                     stall_o     = '0;
                  end else begin
                     pend_addr_d = jump_addr_i;
                     state_d     = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               // The deferred jump wins over any new jump in the release cycle.
               if (!w_blk) begin
                  jump_en_o   = 1'b1;
                  jump_addr_o = pend_addr_q;
                  flush_o     = 1'b1;
                  stall_o     = '0;
                  state_d     = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      cnt_d     = '0;
      timeout_d = 1'b0;
      if (stallreq_mem_i) begin
         cnt_d     = (cnt_q == c_timeout) ? cnt_q : cnt_q + 1'b1;
         timeout_d = (cnt_q == c_timeout - 1'b1);
      end
   end

   assign timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + {31'd0, stall_o[0]};
      flush_cnt_d    = flush_cnt_q + {31'd0, flush_o};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cycles_q <= '0;
         flush_cnt_q    <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_cnt_q    <= flush_cnt_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_cnt_o    = flush_cnt_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         pend_addr_q <= '0;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipe_ctrl                                                  |
// | Purpose  : Self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4).          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_pipe_ctrl;

   localparam int TO = 4;

   logic                   clk = 1'b0;
   logic                   rst_i = 1'b1;
   logic                   id_r = 1'b0, ex_r = 1'b0, mem_r = 1'b0, jen_r = 1'b0;
   logic [`ADDR_WIDTH-1:0] jaddr_r = '0;
   logic [5:0]             stall_o;
   logic                   flush_o, jump_en_o, timeout_o;
   logic [`ADDR_WIDTH-1:0] jump_addr_o;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]            stall_cycles_o, flush_cnt_o;
`endif

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .stallreq_id_i  (id_r),
      .stallreq_ex_i  (ex_r),
      .stallreq_mem_i (mem_r),
      .jump_en_i      (jen_r),
      .jump_addr_i    (jaddr_r),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .jump_en_o      (jump_en_o),
      .jump_addr_o    (jump_addr_o),
`ifdef PIPE_CTRL_PERF_EN
      .stall_cycles_o (stall_cycles_o),
      .flush_cnt_o    (flush_cnt_o),
`endif
      .timeout_o      (timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a pending-jump record plus the length of the current MEM-stall run.
   bit                     m_pend = 1'b0;
   logic [`ADDR_WIDTH-1:0] m_pend_addr = '0;
   int                     m_run = 0;
   bit                     m_to = 1'b0;
   bit                     m_live = 1'b0;

   always @(posedge clk) begin
      if (rst_i) begin
         m_pend = 1'b0;
         m_run  = 0;
         m_to   = 1'b0;
      end else begin
         m_to  = mem_r && (m_run + 1 == TO);
         m_run = mem_r ? m_run + 1 : 0;
         if (!m_pend && jen_r && (mem_r || ex_r)) begin
            m_pend      = 1'b1;
            m_pend_addr = jaddr_r;
         end else if (m_pend && !(mem_r || ex_r)) begin
            m_pend = 1'b0;
         end
      end
      m_live = 1'b1;
   end

   always @(negedge clk) begin
      logic [5:0]             e_stall;
      logic                   e_flush, e_jen;
      logic [`ADDR_WIDTH-1:0] e_addr;
      if (m_live) begin
         e_stall = mem_r ? 6'h1F : ex_r ? 6'h0F : id_r ? 6'h07 : 6'h00;
         e_flush = 1'b0;
         e_jen   = 1'b0;
         e_addr  = '0;
         if (rst_i) begin
            e_stall = '0;
         end else if (!(mem_r || ex_r) && (m_pend || jen_r)) begin
            e_jen   = 1'b1;
            e_flush = 1'b1;
            e_stall = '0;
            e_addr  = m_pend ? m_pend_addr : jaddr_r;
         end
         chk("model_stall", 32'(stall_o), 32'(e_stall));
         chk("model_flush", 32'(flush_o), 32'(e_flush));
         chk("model_jen", 32'(jump_en_o), 32'(e_jen));
         chk("model_jaddr", 32'(jump_addr_o), 32'(e_addr));
         chk("model_timeout", 32'(timeout_o), 32'(m_to));
      end
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic id, input logic ex, input logic mem,
                         input logic jen, input logic [31:0] a);
      id_r = id; ex_r = ex; mem_r = mem; jen_r = jen; jaddr_r = `ADDR_WIDTH'(a);
      #2;
   endtask

   initial begin
      // Reset with every request asserted: all outputs quiet.
      rst_i = 1'b1;
      set_in(1, 1, 1, 1, 32'h0000_0AAA);
      cyc;
      set_in(1, 1, 1, 1, 32'h0000_0AAA);
      chk("rst_stall", 32'(stall_o), 32'h0);
      chk("rst_flush", 32'(flush_o), 32'h0);
      chk("rst_jen", 32'(jump_en_o), 32'h0);
      chk("rst_jaddr", 32'(jump_addr_o), 32'h0);
      chk("rst_timeout", 32'(timeout_o), 32'h0);
      cyc;
      rst_i = 1'b0;
      set_in(1, 0, 0, 0, 0);
      chk("id_only", 32'(stall_o), 32'h07);
      cyc;

      set_in(1, 1, 0, 0, 0);
      chk("ex_id", 32'(stall_o), 32'h0F);
      cyc;
      set_in(1, 1, 1, 0, 0);
      chk("mem_ex_id", 32'(stall_o), 32'h1F);
      cyc;
      set_in(0, 0, 0, 0, 0);
      chk("none", 32'(stall_o), 32'h00);
      cyc;

      // Immediate jump suppresses the ID stall.
      set_in(1, 0, 0, 1, 32'h0000_0100);
      chk("jmp_flush", 32'(flush_o), 32'h1);
      chk("jmp_jen", 32'(jump_en_o), 32'h1);
      chk("jmp_addr", 32'(jump_addr_o), 32'h100);
      chk("jmp_stall", 32'(stall_o), 32'h0);
      cyc;

      // Deferred jump across a 3-cycle MEM stall; a later jump is ignored.
      set_in(0, 0, 1, 1, 32'h0000_0200);
      chk("hold0_jen", 32'(jump_en_o), 32'h0);
      chk("hold0_flush", 32'(flush_o), 32'h0);
      chk("hold0_stall", 32'(stall_o), 32'h1F);
      cyc;
      set_in(0, 0, 1, 1, 32'h0000_0300);
      chk("hold1_jen", 32'(jump_en_o), 32'h0);
      cyc;
      set_in(0, 0, 1, 0, 0);
      chk("hold2_jen", 32'(jump_en_o), 32'h0);
      cyc;
      set_in(0, 0, 0, 1, 32'h0000_0300);
      chk("rel_jen", 32'(jump_en_o), 32'h1);
      chk("rel_addr", 32'(jump_addr_o), 32'h200);
      chk("rel_flush", 32'(flush_o), 32'h1);
      chk("rel_stall", 32'(stall_o), 32'h0);
      cyc;
      set_in(0, 0, 0, 0, 0);
      chk("post_rel_jen", 32'(jump_en_o), 32'h0);
      cyc;

      // Timeout: one pulse per MEM-stall run, the cycle after the 4th counting edge.
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         set_in(0, 0, 1, 0, 0);
         if (k > 0) begin
            chk("to_run1", 32'(timeout_o), (k == TO) ? 32'h1 : 32'h0);
            if (timeout_o === 1'b1) pulses++;
         end
         cyc;
      end
      set_in(0, 0, 0, 0, 0);
      if (timeout_o === 1'b1) pulses++;
      chk("to_pulses", 32'(pulses), 32'h1);
      cyc;
      for (int k = 0; k < TO; k++) begin
         set_in(0, 0, 1, 0, 0);
         if (k > 0) chk("to_run2_quiet", 32'(timeout_o), 32'h0);
         cyc;
      end
      set_in(0, 0, 0, 0, 0);
      chk("to_run2_pulse", 32'(timeout_o), 32'h1);
      cyc;
      set_in(0, 0, 0, 0, 0);
      chk("to_run2_end", 32'(timeout_o), 32'h0);
      cyc;

      // Reset while holding discards the pending jump.
      set_in(0, 1, 0, 1, 32'h0000_0400);
      chk("hr_jen", 32'(jump_en_o), 32'h0);
      cyc;
      rst_i = 1'b1;
      set_in(0, 1, 0, 0, 0);
      cyc;
      rst_i = 1'b0;
      set_in(0, 0, 0, 0, 0);
      chk("hr_after_jen", 32'(jump_en_o), 32'h0);
      chk("hr_after_addr", 32'(jump_addr_o), 32'h0);
      cyc;
      set_in(0, 0, 0, 0, 0);
      chk("hr_after2_jen", 32'(jump_en_o), 32'h0);
      cyc;
      cyc;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
